// File: rtl/ccd_timing_gen_if.sv
// Register-write bus and sample-stream handshake of the CCD timing generator.
// The master drives config writes and samples; the slave (the generator)
// returns s_ready on the cycle a sample is consumed.
interface ccd_timing_gen_if #(
  parameter int DAC_W = 14
);
  logic             cfg_valid;
  logic [3:0]       cfg_addr;
  logic [15:0]      cfg_data;
  logic [DAC_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, s_data, s_valid,
    input  s_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, s_data, s_valid,
    output s_ready
  );
endinterface

// File: rtl/ccd_timing_gen.sv
// CCD / ADC functional-test timing generator.
// Walks a (ph, px, ln) counter nest, fetches one sample per active pixel from
// the stream and produces registered DAC data plus CLK/SHP/SHD/CLPDM/HD/VD.
// Every timing output is a function of the previous cycle's counters.
module ccd_timing_gen #(
  parameter int DAC_W = 14,
  parameter int PH_W  = 8,
  parameter int PIX_W = 10,
  parameter int LN_W  = 10
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_ccd,
  ccd_timing_gen_if.slave  bus,
  output logic [DAC_W-1:0] dac_d,
  output logic             clk_out,
  output logic             shp,
  output logic             shd,
  output logic             clpdm,
  output logic             hd,
  output logic             vd,
  output logic             busy,
  output logic             underrun,
  output logic [1:0]       state_o
);

  // Widths one bit wider than the counters so a full 2^N period/length fits.
  localparam int PW = PH_W + 1;
  localparam int XW = PIX_W + 1;
  localparam int LW = LN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // Phase-domain registers: 0 PERIOD, 1 CLK_FALL, 2 SHP_FALL, 3 SHP_RISE,
  // 4 SHD_FALL, 5 SHD_RISE.
  localparam logic [PW-1:0] EDGE_RST [0:5] = '{
    PW'(16), PW'(8), PW'(2), PW'(6), PW'(10), PW'(14)
  };

  state_t state_q, state_d;

  logic [PW-1:0]    edge_val [0:5];
  logic [DAC_W-1:0] black_q;
  logic [XW-1:0]    line_len_q;
  logic [XW-1:0]    blank_len_q;
  logic [LW-1:0]    frame_lines_q;

  logic [PH_W-1:0]  ph_q;
  logic [PIX_W-1:0] px_q;
  logic [LN_W-1:0]  ln_q;
  logic             mode_q;
  logic [DAC_W-1:0] pix_q;
  logic             underrun_q;

  logic [DAC_W-1:0] dac_q, dac_d_next;
  logic             clk_out_q, clk_out_d;
  logic             shp_q, shp_d;
  logic             shd_q, shd_d;
  logic             clpdm_q, clpdm_d;
  logic             hd_q, hd_d;
  logic             vd_q, vd_d;

  logic [PW-1:0]    period;
  logic [PW-1:0]    ph_ext;
  logic [XW-1:0]    px_ext;
  logic [LW-1:0]    ln_ext;
  logic             cfg_we;
  logic             running;
  logic             start_ok;
  logic             enter_run;
  logic             ph_last, px_last, ln_last, line_end;
  logic             active;
  logic             fetch;
  logic [DAC_W-1:0] fetch_val;

  assign period    = edge_val[0];
  assign ph_ext    = {1'b0, ph_q};
  assign px_ext    = {1'b0, px_q};
  assign ln_ext    = {1'b0, ln_q};
  assign cfg_we    = bus.cfg_valid && (state_q == ST_IDLE);
  assign running   = (state_q != ST_IDLE);
  assign start_ok  = (period >= PW'(4)) && (blank_len_q < line_len_q);
  assign enter_run = (state_q == ST_IDLE) && start && start_ok;
  assign ph_last   = (ph_ext == period - PW'(1));
  assign px_last   = (px_ext == line_len_q - XW'(1));
  assign ln_last   = (ln_ext == frame_lines_q - LW'(1));
  assign line_end  = ph_last && px_last;
  assign active    = (px_ext < (line_len_q - blank_len_q));
  assign fetch     = running && active && (ph_q == '0);
  assign fetch_val = bus.s_valid ? bus.s_data : black_q;

  // Phase-domain config registers, one writable slot per address 0..5.
  for (genvar gi = 0; gi < 6; gi++) begin : g_edge
    logic [PW-1:0] val_q;
    always_ff @(posedge sys_clk) begin
      if (rst)
        val_q <= EDGE_RST[gi];
      else if (cfg_we && (bus.cfg_addr == 4'(gi)))
        val_q <= bus.cfg_data[PW-1:0];
    end
    assign edge_val[gi] = val_q;
  end

  // Remaining config registers: black level, line length, blanking, frame height.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      black_q       <= '0;
      line_len_q    <= XW'(256);
      blank_len_q   <= XW'(10);
      frame_lines_q <= LW'(1);
    end else if (cfg_we) begin
      case (bus.cfg_addr)
        4'd6:    black_q       <= bus.cfg_data[DAC_W-1:0];
        4'd7:    line_len_q    <= bus.cfg_data[XW-1:0];
        4'd8:    blank_len_q   <= bus.cfg_data[XW-1:0];
        4'd9:    frame_lines_q <= bus.cfg_data[LW-1:0];
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; frame completion takes priority over a concurrent stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (enter_run) state_d = ST_RUN;
      ST_RUN: begin
        if (line_end && ln_last) state_d = ST_IDLE;
        else if (stop)           state_d = ST_STOPPING;
      end
      ST_STOPPING: if (line_end) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Phase / pixel / line counters; cleared on entry to RUN and on return to IDLE.
  always_ff @(posedge sys_clk) begin
    if (rst || enter_run || (running && state_d == ST_IDLE)) begin
      ph_q <= '0;
      px_q <= '0;
      ln_q <= '0;
    end else if (running) begin
      if (ph_last) begin
        ph_q <= '0;
        if (px_last) begin
          px_q <= '0;
          ln_q <= ln_q + 1'b1;
        end else begin
          px_q <= px_q + 1'b1;
        end
      end else begin
        ph_q <= ph_q + 1'b1;
      end
    end
  end

  // Mode latch, sample holding register and sticky underrun flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mode_q     <= 1'b0;
      pix_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (enter_run) begin
        mode_q     <= mode_ccd;
        underrun_q <= 1'b0;
      end
      if (fetch) begin
        pix_q <= fetch_val;
        if (!bus.s_valid) underrun_q <= 1'b1;
      end
    end
  end

  // Next value of every timing output from the current counters.
  always_comb begin
    dac_d_next = black_q;
    clk_out_d  = 1'b0;
    shp_d      = 1'b1;
    shd_d      = 1'b1;
    clpdm_d    = 1'b0;
    hd_d       = 1'b0;
    vd_d       = 1'b0;
    if (running) begin
      clk_out_d = (ph_ext < edge_val[1]);
      shp_d     = !((ph_ext >= edge_val[2]) && (ph_ext < edge_val[3]));
      shd_d     = !((ph_ext >= edge_val[4]) && (ph_ext < edge_val[5]));
      clpdm_d   = !active;
      hd_d      = (px_q == '0);
      vd_d      = (ln_q == '0);
      if (active) begin
        if (mode_q && (ph_ext < (period >> 1)))
          dac_d_next = black_q;
        else
          dac_d_next = fetch ? fetch_val : pix_q;
      end
    end
  end

  // Output registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      dac_q     <= '0;
      clk_out_q <= 1'b0;
      shp_q     <= 1'b1;
      shd_q     <= 1'b1;
      clpdm_q   <= 1'b0;
      hd_q      <= 1'b0;
      vd_q      <= 1'b0;
    end else begin
      dac_q     <= dac_d_next;
      clk_out_q <= clk_out_d;
      shp_q     <= shp_d;
      shd_q     <= shd_d;
      clpdm_q   <= clpdm_d;
      hd_q      <= hd_d;
      vd_q      <= vd_d;
    end
  end

  assign bus.s_ready = fetch;
  assign dac_d       = dac_q;
  assign clk_out     = clk_out_q;
  assign shp         = shp_q;
  assign shd         = shd_q;
  assign clpdm       = clpdm_q;
  assign hd          = hd_q;
  assign vd          = vd_q;
  assign busy        = running;
  assign underrun    = underrun_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Directed bench for ccd_timing_gen: defaults in plain mode, CCD halves,
// multi-line frames, underrun, stop/ignored writes, and mid-line reset.
module tb_ccd_timing_gen;

  localparam int DAC_W = 14;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode_ccd = 1'b0;
  logic [DAC_W-1:0] dac_d;
  logic             clk_out, shp, shd, clpdm, hd, vd, busy, underrun;
  logic [1:0]       state_o;

  ccd_timing_gen_if #(.DAC_W(DAC_W)) sif ();

  ccd_timing_gen #(.DAC_W(DAC_W)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode_ccd (mode_ccd),
    .bus      (sif.slave),
    .dac_d    (dac_d),
    .clk_out  (clk_out),
    .shp      (shp),
    .shd      (shd),
    .clpdm    (clpdm),
    .hd       (hd),
    .vd       (vd),
    .busy     (busy),
    .underrun (underrun),
    .state_o  (state_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int consumed = 0;
  int cons0 = 0;
  logic [DAC_W-1:0] s_base = '0;
  bit s_incr = 1'b0;

  // Sample source: either a constant or base + index of the sample within the run.
  assign sif.s_data = s_base + (s_incr ? DAC_W'(consumed - cons0) : DAC_W'(0));

  always @(posedge sys_clk)
    if (sif.s_valid && sif.s_ready) consumed <= consumed + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s t=%0d obs=%0h exp=%0h ok", tag, k, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic adv_to(input int t);
    while (k < t) begin
      @(negedge sys_clk);
      k++;
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    sif.cfg_valid = 1'b1;
    sif.cfg_addr  = a;
    sif.cfg_data  = d;
    @(negedge sys_clk);
    sif.cfg_valid = 1'b0;
  endtask

  // Pulse start for one edge; afterwards k=0 is the first counter cycle (ph=0,px=0).
  task automatic do_start(input logic m);
    cons0    = consumed;
    start    = 1'b1;
    mode_ccd = m;
    @(negedge sys_clk);
    start = 1'b0;
    k = 0;
  endtask

  int hd_rise;
  int vd_cnt;
  logic hd_prev;

  initial begin
    sif.cfg_valid = 1'b0;
    sif.cfg_addr  = '0;
    sif.cfg_data  = '0;
    sif.s_valid   = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Reset state
    chk("rst_dac", dac_d, 0);
    chk("rst_clk", clk_out, 0);
    chk("rst_shp", shp, 1);
    chk("rst_shd", shd, 1);
    chk("rst_misc", {clpdm, hd, vd, sif.s_ready, busy, underrun}, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;
    @(negedge sys_clk);

    // Defaults, plain mode, incrementing samples from 0x100
    s_base = 14'h100; s_incr = 1'b1;
    do_start(1'b0);
    chk("t1_ready", sif.s_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_state", state_o, 1);
    adv_to(1);
    chk("t1_dac_first", dac_d, 14'h100);
    chk("t1_hdvd_first", {hd, vd, clk_out}, 3'b111);
    adv_to(3);
    chk("t1_shp_ph2", {shp, shd}, 2'b01);
    adv_to(9);
    chk("t1_clk_ph8", clk_out, 0);
    adv_to(11);
    chk("t1_shd_ph10", {shp, shd}, 2'b10);
    adv_to(16);
    chk("t1_pix0_last", {hd, dac_d}, {1'b1, 14'h100});
    adv_to(17);
    chk("t1_pix1_first", {hd, dac_d}, {1'b0, 14'h101});
    adv_to(3936);
    chk("t1_px245", {clpdm, dac_d}, {1'b0, 14'h1F5});
    adv_to(3937);
    chk("t1_px246_blank", {clpdm, dac_d}, {1'b1, 14'h000});
    adv_to(4095);
    chk("t1_busy_4095", busy, 1);
    adv_to(4096);
    chk("t1_idle_4096", {busy, state_o}, 0);
    chk("t1_consumed", consumed - cons0, 246);
    chk("t1_underrun", underrun, 0);

    // CCD mode: BLACK=0x2A0, constant sample 0x1FFF, short line
    cfg_write(4'd6, 16'h02A0);
    cfg_write(4'd7, 16'd20);
    cfg_write(4'd8, 16'd4);
    s_base = 14'h1FFF; s_incr = 1'b0;
    do_start(1'b1);
    adv_to(1);
    chk("t2_ph0_black", dac_d, 14'h2A0);
    adv_to(3);
    chk("t2_shp_ph2", shp, 0);
    adv_to(6);
    chk("t2_shp_ph5", shp, 0);
    adv_to(7);
    chk("t2_shp_ph6", shp, 1);
    adv_to(8);
    chk("t2_ph7_black", dac_d, 14'h2A0);
    adv_to(9);
    chk("t2_ph8_video", dac_d, 14'h1FFF);
    adv_to(11);
    chk("t2_shd_ph10", shd, 0);
    adv_to(14);
    chk("t2_shd_ph13", shd, 0);
    adv_to(15);
    chk("t2_shd_ph14", shd, 1);
    adv_to(16);
    chk("t2_ph15_video", dac_d, 14'h1FFF);
    adv_to(17);
    chk("t2_px1_black", dac_d, 14'h2A0);
    adv_to(257);
    chk("t2_blank", {clpdm, dac_d}, {1'b1, 14'h2A0});
    adv_to(320);
    chk("t2_idle", busy, 0);
    adv_to(321);
    chk("t2_idle_dac", {dac_d, shp, shd, clk_out}, {14'h2A0, 3'b110});

    // Multi-line frame: PERIOD=8, 20-pixel lines, 4 blanking, 3 lines
    cfg_write(4'd0, 16'd8);
    cfg_write(4'd9, 16'd3);
    cfg_write(4'd6, 16'h0000);
    s_base = 14'h300; s_incr = 1'b1;
    do_start(1'b0);
    hd_rise = 0; vd_cnt = 0; hd_prev = 1'b0;
    for (int t = 1; t <= 480; t++) begin
      adv_to(t);
      if (hd && !hd_prev) hd_rise++;
      hd_prev = hd;
      if (vd) vd_cnt++;
      if (t == 161) chk("t3_vd_drop", vd, 0);
      if (t == 161) chk("t3_hd_line1", hd, 1);
      if (t == 479) chk("t3_busy_479", busy, 1);
      if (t == 480) chk("t3_busy_480", busy, 0);
    end
    chk("t3_hd_pulses", hd_rise, 3);
    chk("t3_vd_cycles", vd_cnt, 160);
    chk("t3_consumed", consumed - cons0, 48);

    // Underrun at px=5
    cfg_write(4'd6, 16'h0055);
    s_base = 14'h200; s_incr = 1'b1;
    do_start(1'b0);
    adv_to(33);
    chk("t4_px4", dac_d, 14'h204);
    adv_to(40);
    chk("t4_fetch_px5", sif.s_ready, 1);
    sif.s_valid = 1'b0;
    adv_to(41);
    sif.s_valid = 1'b1;
    chk("t4_px5_black", {underrun, dac_d}, {1'b1, 14'h055});
    adv_to(48);
    chk("t4_px5_hold", dac_d, 14'h055);
    adv_to(49);
    chk("t4_px6", dac_d, 14'h205);
    adv_to(480);
    chk("t4_sticky", {underrun, busy}, 2'b10);

    // New start clears underrun; write in RUN ignored; stop at px=7
    do_start(1'b0);
    chk("t5_underrun_clr", underrun, 0);
    adv_to(2);
    sif.cfg_valid = 1'b1; sif.cfg_addr = 4'd0; sif.cfg_data = 16'd16;
    adv_to(3);
    sif.cfg_valid = 1'b0;
    adv_to(8);
    chk("t5_period_kept", sif.s_ready, 1);
    adv_to(56);
    stop = 1'b1;
    adv_to(57);
    stop = 1'b0;
    chk("t5_stopping", state_o, 2);
    adv_to(159);
    chk("t5_stop_busy", {busy, state_o}, 3'b110);
    adv_to(160);
    chk("t5_stop_idle", {busy, state_o}, 0);
    cfg_write(4'd0, 16'd3);
    do_start(1'b0);
    adv_to(2);
    chk("t5_bad_period", busy, 0);
    cfg_write(4'd0, 16'd8);

    // Reset mid-line restores outputs and registers
    cfg_write(4'd6, 16'h0123);
    do_start(1'b0);
    adv_to(13);
    rst = 1'b1;
    adv_to(14);
    chk("t6_dac", dac_d, 0);
    chk("t6_outs", {clk_out, shp, shd, clpdm, hd, vd}, 6'b011000);
    chk("t6_busy", {busy, state_o, underrun, sif.s_ready}, 0);
    rst = 1'b0;
    adv_to(15);
    do_start(1'b0);
    adv_to(8);
    chk("t6_period16_ready", sif.s_ready, 0);
    adv_to(9);
    chk("t6_period16_hd", {hd, clk_out}, 2'b10);
    rst = 1'b1;
    adv_to(11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
